// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - prefetch queue bundle: redirect, imem request/ack, IF/ID output stream
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_ready;

    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction prefetch with single-outstanding imem handshake and {pc,instr} FIFO
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] addr_q;
    logic            req_q;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic has_space;
    logic push;
    logic pop;

    assign has_space = (count < CW'(DEPTH));
    assign pop       = (count != '0) && bus.out_ready;
    // A redirect in the ack cycle kills the returning word: it belongs to the old path.
    assign push      = (state == REQ) && bus.imem_ack && !bus.redirect;

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : NOP;
    assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            fetch_pc <= '0;
        end else begin
            if (bus.redirect) begin
                fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end

            case (state)
                IDLE: begin
                    if (!bus.redirect && has_space) begin
                        state  <= REQ;
                        req_q  <= 1'b1;
                        addr_q <= fetch_pc;
                    end
                end
                REQ: begin
                    // An unacked request cannot be withdrawn, so wait it out in DRAIN.
                    if (bus.redirect && !bus.imem_ack) begin
                        state <= DRAIN;
                    end else if (bus.imem_ack) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack && !bus.redirect) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= addr_q;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random stimulus against a queue-based model of fetch_queue
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: an in-flight flag, a stale flag for a request orphaned by redirect,
    // the address presented to memory, the next fetch PC and a queue of {pc, instr}.
    bit          m_known = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_stale = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_fpc   = '0;
    logic [63:0] m_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic rdy);
        int  sz;
        bit  was_busy;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        @(negedge clk);
        if (m_known) begin
            sz      = m_q.size();
            e_pc    = (sz != 0) ? m_q[0][63:32] : 32'h0;
            e_instr = (sz != 0) ? m_q[0][31:0]  : NOP;
            check("imem_req",  {31'h0, bus.imem_req},  {31'h0, m_busy});
            check("imem_addr", bus.imem_addr, m_addr);
            check("out_valid", {31'h0, bus.out_valid}, (sz != 0) ? 32'h1 : 32'h0);
            check("out_pc",    bus.out_pc,    e_pc);
            check("out_instr", bus.out_instr, e_instr);
        end
        rst             = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ack    = ack;
        bus.imem_rdata  = mem_word(m_addr);
        bus.out_ready   = rdy;
        @(posedge clk);
        sz       = m_q.size();
        was_busy = m_busy;
        if (r) begin
            m_q.delete();
            m_fpc   = '0;
            m_addr  = '0;
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_known = 1'b1;
        end else if (rd) begin
            m_q.delete();
            m_fpc = {rpc[31:2], 2'b00};
            if (m_busy && !m_stale) begin
                if (ack) m_busy = 1'b0;
                else     m_stale = 1'b1;
            end
        end else begin
            if (sz != 0 && rdy) void'(m_q.pop_front());
            if (m_busy && !m_stale && ack) begin
                m_q.push_back({m_addr, mem_word(m_addr)});
                m_fpc  = m_fpc + 32'd4;
                m_busy = 1'b0;
            end else if (m_busy && m_stale && ack) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (!was_busy && sz < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    initial begin
        logic [31:0] rpc;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.out_ready   = 1'b0;

        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // zero-wait streaming
        repeat (12) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // backpressure until full, then one pop reopens a single fetch
        repeat (14) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // fill to three, then push and pop together so pointers wrap at constant count
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (20) begin
            if (m_q.size() == 3 && m_busy) break;
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        repeat (12) cyc(1'b0, 1'b0, 32'h0, 1'b1, m_busy);

        // reset while holding three entries with a request in flight
        repeat (4) begin
            if (m_busy) break;
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // redirect while the request for pc 8 waits; drain completes three cycles later
        repeat (20) begin
            if (m_busy && m_addr == 32'h8) break;
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // redirect in the same cycle as the ack for pc 12
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (20) begin
            if (m_busy && m_addr == 32'hC) break;
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        cyc(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // random traffic, including targets near the top of the address space
        repeat (1500) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), rpc,
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
